alu_iterative: RTL and testbench

Parametrised, multi-cycle successor to the datapath ALU. It executes the existing 6-bit ALU operation set at configurable `WIDTH`. Single-cycle operations complete with one-cycle registered latency. `mul` and `div` run as iterative shift-add and restoring-divide sequences. A valid/ready handshake on both sides lets the EX stage stall on long operations instead of closing timing on a combinational multiplier/divider.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_muldiv_iter.sv | 70 +++++++
 rtl/alu_iterative.sv | 135 +++++++++++++
 tb/tb_alu_iterative.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the iterative ALU.
// The optional divider is selected by the ALU_ITER_DIV_EN macro in the users of this package.
package alu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'd0;
  localparam logic [5:0] ALU_ADD2  = 6'd2;
  localparam logic [5:0] ALU_ADD3  = 6'd3;
  localparam logic [5:0] ALU_SUB   = 6'd4;
  localparam logic [5:0] ALU_MUL   = 6'd5;
  localparam logic [5:0] ALU_ADDI  = 6'd10;
  localparam logic [5:0] ALU_ADDIU = 6'd11;
  localparam logic [5:0] ALU_BEQ   = 6'd18;
  localparam logic [5:0] ALU_BNE   = 6'd19;
  localparam logic [5:0] ALU_Z23   = 6'd23;
  localparam logic [5:0] ALU_Z24   = 6'd24;
  localparam logic [5:0] ALU_Z25   = 6'd25;
  localparam logic [5:0] ALU_AND   = 6'd27;
  localparam logic [5:0] ALU_OR    = 6'd31;
  localparam logic [5:0] ALU_SLL   = 6'd34;
  localparam logic [5:0] ALU_SRL   = 6'd35;
  localparam logic [5:0] ALU_SLT   = 6'd38;
  localparam logic [5:0] ALU_SLTI  = 6'd39;
  localparam logic [5:0] ALU_ABS   = 6'd40;
  localparam logic [5:0] ALU_DIV   = 6'd51;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared 2*WIDTH accumulator for shift-add multiply and restoring divide (one step per cycle).
// The divide step exists only when ALU_ITER_DIV_EN is defined.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               active;
  logic               mode_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     mul_sum;
`ifdef ALU_ITER_DIV_EN
  logic [WIDTH:0]     diff;
`endif

  // mul: acc = {partial, multiplier}; div: acc = {remainder, dividend/quotient}
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc[0]}}};
    acc_nxt = {mul_sum, acc[WIDTH-1:1]};
`ifdef ALU_ITER_DIV_EN
    diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (mode_q) begin
      if (diff[WIDTH]) acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
      else             acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
`else
    if (mode_q) acc_nxt = acc;
`endif
  end

  assign done   = active && (cnt == LAST);
  assign result = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      mode_q <= 1'b0;
      cnt    <= '0;
      opnd   <= '0;
      acc    <= '0;
    end else if (start) begin
      active <= 1'b1;
      mode_q <= mode;
      cnt    <= '0;
      opnd   <= mode ? b : a;
      acc    <= {{WIDTH{1'b0}}, (mode ? a : b)};
    end else if (active) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (cnt == LAST) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// Multi-cycle ALU with valid/ready on both sides; mul/div iterate, everything else takes one cycle.
// Define ALU_ITER_DIV_EN to build the restoring divider for opcode 51.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SAW   = $clog2(WIDTH)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               InValid,
  output logic               InReady,
  input  logic [5:0]         ALUControl,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SAW-1:0]     sa,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [2*WIDTH-1:0] ALUResult,
  output logic               Zero,
  output logic               DivByZero,
  output logic               Busy,
  output logic [1:0]         dbg_state
);

  state_t state, state_nxt;

  logic               accept;
  logic               is_iter;
  logic               dbz_c;
  logic [2*WIDTH-1:0] sc_res;
  logic               sc_zero;
  logic               md_done;
  logic [2*WIDTH-1:0] md_result;
  logic [2*WIDTH-1:0] res_q;
  logic               zero_q;
  logic               dbz_q;

  // Handshake: a request is taken when InValid && InReady; a result leaves when OutValid && OutReady.
  // DONE with OutReady high frees the output slot and may take a new request in the same cycle.
  assign InReady = (state == IDLE) || ((state == DONE) && OutReady);
  assign accept  = InValid && InReady;

`ifdef ALU_ITER_DIV_EN
  assign is_iter = (ALUControl == ALU_MUL) || ((ALUControl == ALU_DIV) && (B != '0));
  assign dbz_c   = (ALUControl == ALU_DIV) && (B == '0);
`else
  assign is_iter = (ALUControl == ALU_MUL);
  assign dbz_c   = 1'b0;
`endif

  always_comb begin
    sc_res = '0;
    case (ALUControl)
      ALU_ADD, ALU_ADD2, ALU_ADD3, ALU_ADDI, ALU_ADDIU:
                    sc_res[WIDTH-1:0] = A + B;
      ALU_SUB:      sc_res[WIDTH-1:0] = A - B;
      ALU_AND:      sc_res[WIDTH-1:0] = A & B;
      ALU_OR:       sc_res[WIDTH-1:0] = A | B;
      ALU_SLL:      sc_res[WIDTH-1:0] = B << sa;
      ALU_SRL:      sc_res[WIDTH-1:0] = B >> sa;
      ALU_SLT, ALU_SLTI:
                    sc_res[0] = $signed(A) < $signed(B);
      ALU_ABS:      sc_res[WIDTH-1:0] = (A >= B) ? (A - B) : (B - A);
`ifdef ALU_ITER_DIV_EN
      // only reaches the output for B==0: quotient all ones, remainder A
      ALU_DIV:      sc_res = {A, {WIDTH{1'b1}}};
`endif
      default:      sc_res = '0;
    endcase

    case (ALUControl)
      ALU_BEQ:                   sc_zero = (A == B);
      ALU_BNE:                   sc_zero = (A != B);
      ALU_Z23, ALU_Z24, ALU_Z25: sc_zero = 1'b1;
      default:                   sc_zero = (sc_res == '0);
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_iter ? BUSY : DONE;
      BUSY: if (md_done) state_nxt = DONE;
      DONE: begin
        if (OutReady) begin
          if (InValid) state_nxt = is_iter ? BUSY : DONE;
          else         state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else if (accept) begin
      dbz_q <= dbz_c;
      if (!is_iter) begin
        res_q  <= sc_res;
        zero_q <= sc_zero;
      end
    end else if ((state == BUSY) && md_done) begin
      res_q  <= md_result;
      zero_q <= (md_result == '0);
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (Clk),
    .rst_n  (Rst),
    .start  (accept && is_iter),
    .mode   (ALUControl == ALU_DIV),
    .a      (A),
    .b      (B),
    .done   (md_done),
    .result (md_result)
  );

  assign OutValid  = (state == DONE);
  assign Busy      = (state == BUSY);
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign DivByZero = dbz_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative at WIDTH=32 and WIDTH=8; divide expectations follow ALU_ITER_DIV_EN.
module tb_alu_iterative;

  logic clk = 1'b0;
  logic rst_n;

  logic        in_valid;
  logic [5:0]  op;
  logic [31:0] a, b;
  logic [4:0]  sa;
  logic        out_ready;
  logic        in_ready, out_valid, zero, dbz, busy;
  logic [63:0] res;
  logic [1:0]  state;

  logic        e_valid;
  logic [5:0]  e_op;
  logic [7:0]  e_a, e_b;
  logic [2:0]  e_sa;
  logic        e_out_ready;
  logic        e_in_ready, e_out_valid, e_zero, e_dbz, e_busy;
  logic [15:0] e_res;
  logic [1:0]  e_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  int  edges, busy_n;
  bit  ready_seen, bad;

  alu_iterative #(.WIDTH(32)) u32 (
    .Clk(clk), .Rst(rst_n), .InValid(in_valid), .InReady(in_ready),
    .ALUControl(op), .A(a), .B(b), .sa(sa), .OutValid(out_valid),
    .OutReady(out_ready), .ALUResult(res), .Zero(zero), .DivByZero(dbz),
    .Busy(busy), .dbg_state(state)
  );

  alu_iterative #(.WIDTH(8)) u8 (
    .Clk(clk), .Rst(rst_n), .InValid(e_valid), .InReady(e_in_ready),
    .ALUControl(e_op), .A(e_a), .B(e_b), .sa(e_sa), .OutValid(e_out_valid),
    .OutReady(e_out_ready), .ALUResult(e_res), .Zero(e_zero), .DivByZero(e_dbz),
    .Busy(e_busy), .dbg_state(e_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // drivers
  task automatic drive(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    sa = s;
  endtask

  task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s, output int n_edges, output int n_busy,
                       output bit rdy_seen);
    drive(o, x, y, s);
    step();
    in_valid = 1'b0;
    n_edges  = 1;
    n_busy   = 0;
    rdy_seen = 1'b0;
    while (!out_valid && n_edges < 100) begin
      if (busy) n_busy++;
      if (in_ready) rdy_seen = 1'b1;
      step();
      n_edges++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; op = '0; a = '0; b = '0; sa = '0; out_ready = 1'b1;
    e_valid = 1'b0; e_op = '0; e_a = '0; e_b = '0; e_sa = '0; e_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", res, 64'h0);
    check("rst_zero", {63'h0, zero}, 64'h0);
    check("rst_dbz", {63'h0, dbz}, 64'h0);
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_state", {62'h0, state}, 64'h0);
    rst_n = 1'b1;
    step();

    // add wraps to zero
    issue(6'd0, 32'hFFFF_FFFF, 32'h1, 5'd0, edges, busy_n, ready_seen);
    check("add_edges", 64'(edges), 64'd1);
    exp_q.push_back(64'h0);
    check("add_result", res, exp_q.pop_front());
    check("add_zero", {63'h0, zero}, 64'h1);
    check("add_out_valid", {63'h0, out_valid}, 64'h1);

    // full-width multiply
    issue(6'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, edges, busy_n, ready_seen);
    check("mul_edges", 64'(edges), 64'd33);
    check("mul_busy_cycles", 64'(busy_n), 64'd32);
    check("mul_in_ready_low", {63'h0, ready_seen}, 64'h0);
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    check("mul_result", res, exp_q.pop_front());
    check("mul_zero", {63'h0, zero}, 64'h0);

    // divide and divide-by-zero
    issue(6'd51, 32'd100, 32'd7, 5'd0, edges, busy_n, ready_seen);
`ifdef ALU_ITER_DIV_EN
    check("div_edges", 64'(edges), 64'd33);
    check("div_result", res, 64'h0000_0002_0000_000E);
    check("div_zero", {63'h0, zero}, 64'h0);
`else
    check("div_edges", 64'(edges), 64'd1);
    check("div_result", res, 64'h0);
    check("div_zero", {63'h0, zero}, 64'h1);
`endif
    check("div_dbz", {63'h0, dbz}, 64'h0);

    issue(6'd51, 32'd5, 32'd0, 5'd0, edges, busy_n, ready_seen);
    check("div0_edges", 64'(edges), 64'd1);
`ifdef ALU_ITER_DIV_EN
    check("div0_result", res, 64'h0000_0005_FFFF_FFFF);
    check("div0_dbz", {63'h0, dbz}, 64'h1);
`else
    check("div0_result", res, 64'h0);
    check("div0_dbz", {63'h0, dbz}, 64'h0);
`endif

    // hold the result with OutReady low, then back-to-back accept
    step();
    out_ready = 1'b0;
    issue(6'd4, 32'd10, 32'd3, 5'd0, edges, busy_n, ready_seen);
    check("sub_result", res, 64'd7);
    check("sub_dbz_cleared", {63'h0, dbz}, 64'h0);
    drive(6'd38, 32'hFFFF_FFFF, 32'h0, 5'd0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready || !out_valid || res !== 64'd7) bad = 1'b1;
      step();
    end
    check("hold_stable", {63'h0, bad}, 64'h0);
    out_ready = 1'b1;
    #1;
    check("hold_release_in_ready", {63'h0, in_ready}, 64'h1);
    step();
    in_valid = 1'b0;
    check("slt_result", res, 64'h1);
    check("slt_out_valid", {63'h0, out_valid}, 64'h1);

    // one result per cycle with OutReady held high
    drive(6'd0, 32'd1, 32'd2, 5'd0);
    exp_q.push_back(64'd3);
    step();
    check("b2b_first", res, exp_q.pop_front());
    drive(6'd27, 32'hF0, 32'h3C, 5'd0);
    exp_q.push_back(64'h30);
    step();
    in_valid = 1'b0;
    check("b2b_second", res, exp_q.pop_front());
    check("b2b_out_valid", {63'h0, out_valid}, 64'h1);

    // asynchronous reset in the middle of a multiply
    drive(6'd5, 32'h1234_5678, 32'h1234_5678, 5'd0);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    check("midmul_busy", {63'h0, busy}, 64'h1);
    rst_n = 1'b0;
    #2;
    check("midrst_result", res, 64'h0);
    check("midrst_zero", {63'h0, zero}, 64'h0);
    check("midrst_dbz", {63'h0, dbz}, 64'h0);
    check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_state", {62'h0, state}, 64'h0);
    step();
    rst_n = 1'b1;
    step();
    issue(6'd18, 32'd3, 32'd3, 5'd0, edges, busy_n, ready_seen);
    check("beq_edges", 64'(edges), 64'd1);
    check("beq_zero", {63'h0, zero}, 64'h1);
    check("beq_result", res, 64'h0);
    issue(6'd19, 32'd3, 32'd3, 5'd0, edges, busy_n, ready_seen);
    check("bne_equal_zero", {63'h0, zero}, 64'h0);
    issue(6'd35, 32'd0, 32'h8000_0000, 5'd31, edges, busy_n, ready_seen);
    check("srl_result", res, 64'h1);

    // WIDTH=8 instance
    e_valid = 1'b1; e_op = 6'd34; e_a = 8'd0; e_b = 8'h81; e_sa = 3'd1;
    step();
    e_valid = 1'b0;
    check("w8_sll_result", {48'h0, e_res}, 64'h0002);
    check("w8_sll_out_valid", {63'h0, e_out_valid}, 64'h1);
    e_valid = 1'b1; e_op = 6'd40; e_a = 8'd3; e_b = 8'd200; e_sa = 3'd0;
    step();
    e_valid = 1'b0;
    check("w8_abs_result", {48'h0, e_res}, 64'd197);
    e_valid = 1'b1; e_op = 6'd5; e_a = 8'hFF; e_b = 8'hFF;
    step();
    e_valid = 1'b0;
    edges = 1;
    while (!e_out_valid && edges < 100) begin
      step();
      edges++;
    end
    check("w8_mul_edges", 64'(edges), 64'd9);
    check("w8_mul_result", {48'h0, e_res}, 64'hFE01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
